// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-lookahead add/subtract controller.
package cla_pkg;

  // Controller states: waiting for operands, stepping nibbles, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the carry-lookahead slice that the controller reuses every cycle.
  localparam int SLICE_W = 4;

endpackage : cla_pkg

// File: rtl/cadd4.sv
// 4-bit carry-lookahead adder slice: all carries come straight from
// generate/propagate terms and the carry-in, with no rippling between bits.
module cadd4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];

endmodule : cadd4

// File: rtl/cla_serial_add_ctrl.sv
// Serial add/subtract controller: one 4-bit CLA slice is stepped across a
// WIDTH-bit operand pair, LSB nibble first, with the carry registered between
// nibbles. Subtraction is A + ~B + 1.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds in_* stable while in_valid is high and in_ready is
// low; in_ready depends only on state (high in IDLE). The result is offered
// with out_valid in DONE and out_* stay stable until out_valid && out_ready.
module cla_serial_add_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("cla_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nx;
  logic [WIDTH-1:0] b_eff;
  logic [3:0]       sl_s;
  logic             sl_co;
  logic             accept;
  logic             last_step;

  // The single shared slice always works on the low nibble of the shifters.
  cadd4 u_slice (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_co)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign last_step = (state == RUN) && (cnt == CNT_W'(NSLICE - 1));
  assign b_eff     = in_sub ? ~in_b : in_b;

  // New slice result enters at the top so the finished sum ends up LSB-aligned.
  assign sum_nx = (sum_sh >> SLICE_W) | (WIDTH'(sl_s) << (WIDTH - SLICE_W));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand shifters, carry, nibble counter and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        a_sh  <= in_a;
        b_sh  <= b_eff;
        carry <= in_sub ? 1'b1 : in_cin;
        a_msb <= in_a[WIDTH-1];
        b_msb <= b_eff[WIDTH-1];
        cnt   <= '0;
      end else if (state == RUN) begin
        carry  <= sl_co;
        sum_sh <= sum_nx;
        a_sh   <= a_sh >> SLICE_W;
        b_sh   <= b_sh >> SLICE_W;
        cnt    <= cnt + CNT_W'(1);
        if (last_step) begin
          out_sum  <= sum_nx;
          out_cout <= sl_co;
          // Overflow: like-signed operands giving a result of the other sign.
          out_ovf  <= (a_msb == b_msb) && (sum_nx[WIDTH-1] != a_msb);
        end
      end
    end
  end

endmodule : cla_serial_add_ctrl

// File: tb/tb_cla_serial_add_ctrl.sv
// Bench for cla_serial_add_ctrl: directed cases on a 16-bit instance, then
// randomized add/sub traffic with valid/ready stalls on 4-, 16- and 32-bit
// instances scored against an arithmetic reference model.
module tb_cla_serial_add_ctrl;

  localparam int NOPS = 1000;

  logic clk;
  logic rst;
  logic rand_go;
  int   n_chk;
  int   n_bad;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum[31:0]}.
  function automatic logic [63:0] model(input int w, input longint a, input longint b,
                                        input bit sub, input bit cin);
    longint m  = longint'(1) << w;
    longint h  = m / 2;
    longint sa = (a >= h) ? a - m : a;
    longint sb = (b >= h) ? b - m : b;
    longint r;
    longint s;
    bit     co;
    bit     ov;
    if (sub) begin
      r  = a - b;
      co = (a >= b);
      s  = sa - sb;
    end else begin
      r  = a + b + longint'(cin);
      co = (r >= m);
      s  = sa + sb + longint'(cin);
    end
    ov = (s < -h) || (s >= h);
    r  = ((r % m) + m) % m;
    return {30'b0, ov, co, r[31:0]};
  endfunction

  // ---------------- directed 16-bit instance ----------------
  logic        d_in_valid, d_in_ready, d_in_sub, d_in_cin;
  logic        d_out_valid, d_out_ready, d_out_cout, d_out_ovf, d_busy;
  logic [15:0] d_in_a, d_in_b, d_out_sum;

  cla_serial_add_ctrl #(.WIDTH(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d_in_valid),
    .in_ready  (d_in_ready),
    .in_a      (d_in_a),
    .in_b      (d_in_b),
    .in_sub    (d_in_sub),
    .in_cin    (d_in_cin),
    .out_valid (d_out_valid),
    .out_ready (d_out_ready),
    .out_sum   (d_out_sum),
    .out_cout  (d_out_cout),
    .out_ovf   (d_out_ovf),
    .busy      (d_busy)
  );

  // Present one operation and wait for the accepting edge; then scramble inputs.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic sub,
                       input logic cin, input string tag);
    d_in_a = a; d_in_b = b; d_in_sub = sub; d_in_cin = cin; d_in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(d_in_ready), 64'd1);
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    d_in_a = 16'($urandom); d_in_b = 16'($urandom);
    d_in_sub = ~sub; d_in_cin = ~cin;
  endtask

  // Count edges until out_valid, then check latency and the result.
  task automatic wait_result(input logic [15:0] es, input logic ec, input logic eo,
                             input string tag);
    int lat = 0;
    while (d_out_valid !== 1'b1 && lat < 20) begin
      check({tag, "_rdy_busy"}, 64'({d_in_ready, d_busy}), 64'b01);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_sum"},  64'(d_out_sum),  64'(es));
    check({tag, "_cout"}, 64'(d_out_cout), 64'(ec));
    check({tag, "_ovf"},  64'(d_out_ovf),  64'(eo));
  endtask

  // Take the result; the controller goes idle and keeps the result registers.
  task automatic take(input logic [15:0] es, input string tag);
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    check({tag, "_idle"}, 64'({d_out_valid, d_in_ready, d_busy}), 64'b010);
    check({tag, "_held"}, 64'(d_out_sum), 64'(es));
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic cin, input logic [15:0] es, input logic ec,
                        input logic eo, input string tag);
    issue(a, b, sub, cin, tag);
    wait_result(es, ec, eo, tag);
    take(es, tag);
  endtask

  // ---------------- randomized instances ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int W = (gi == 0) ? 4 : (gi == 1) ? 16 : 32;

    logic         r_in_valid, r_in_ready, r_in_sub, r_in_cin;
    logic         r_out_valid, r_out_ready, r_out_cout, r_out_ovf, r_busy;
    logic [W-1:0] r_in_a, r_in_b, r_out_sum;
    logic [63:0]  exp_q[$];
    int           acc_n;
    int           done_n;
    bit           fin;

    cla_serial_add_ctrl #(.WIDTH(W)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .in_a      (r_in_a),
      .in_b      (r_in_b),
      .in_sub    (r_in_sub),
      .in_cin    (r_in_cin),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready),
      .out_sum   (r_out_sum),
      .out_cout  (r_out_cout),
      .out_ovf   (r_out_ovf),
      .busy      (r_busy)
    );

    // Driver: random operands every cycle, random valid and ready stalls.
    initial begin
      r_in_valid = 1'b0; r_in_sub = 1'b0; r_in_cin = 1'b0; r_out_ready = 1'b0;
      r_in_a = '0; r_in_b = '0;
      acc_n = 0; done_n = 0; fin = 1'b0;
      wait (rand_go);
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 40000 && done_n < NOPS; cyc++) begin
        r_in_valid  = (acc_n < NOPS) && ($urandom_range(0, 3) != 0);
        r_in_a      = W'($urandom);
        r_in_b      = W'($urandom);
        r_in_sub    = 1'($urandom_range(0, 1));
        r_in_cin    = 1'($urandom_range(0, 1));
        r_out_ready = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
      end
      r_in_valid = 1'b0;
      check($sformatf("w%0d_ops_done", W), 64'(done_n), 64'(NOPS));
      check($sformatf("w%0d_q_empty", W), 64'(exp_q.size()), 64'd0);
      fin = 1'b1;
    end

    // Scoreboard: handshakes seen at negedge complete on the next rising edge.
    always @(negedge clk) begin
      if (rand_go && !rst) begin
        if (r_in_valid && r_in_ready) begin
          exp_q.push_back(model(W, longint'(r_in_a), longint'(r_in_b), r_in_sub, r_in_cin));
          acc_n++;
        end
        if (r_out_valid && r_out_ready) begin
          if (exp_q.size() == 0) begin
            check($sformatf("w%0d_spurious", W), 64'd1, 64'd0);
          end else begin
            check($sformatf("w%0d_result", W),
                  {30'b0, r_out_ovf, r_out_cout, 32'(r_out_sum)}, exp_q.pop_front());
          end
          done_n++;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    n_chk = 0; n_bad = 0; rand_go = 1'b0;
    rst = 1'b1;
    d_in_valid = 1'b0; d_in_a = '0; d_in_b = '0; d_in_sub = 1'b0; d_in_cin = 1'b0;
    d_out_ready = 1'b0;
    #2;
    check("reset_flags", 64'({d_out_valid, d_in_ready, d_busy, d_out_cout, d_out_ovf}),
          64'b01000);
    check("reset_sum", 64'(d_out_sum), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Plain add, carry chain, signed overflow.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_chain");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    run_op(16'h1000, 16'h0FFF, 1'b0, 1'b1, 16'h2000, 1'b0, 1'b0, "add_cin");

    // Subtraction, with in_cin both ways to show it is ignored.
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, "sub_neg_c0");
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg_c1");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf_c0");
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf_c1");

    // Backpressure: result held while new requests are offered and ignored.
    issue(16'h1234, 16'h4321, 1'b0, 1'b0, "bp");
    wait_result(16'h5555, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      d_in_valid = 1'b1; d_in_a = 16'($urandom); d_in_b = 16'($urandom);
      @(negedge clk);
      check("bp_hold_flags", 64'({d_out_valid, d_in_ready, d_busy}), 64'b101);
      check("bp_hold_res", {46'b0, d_out_ovf, d_out_cout, d_out_sum}, 64'h5555);
      @(posedge clk); #1;
    end
    d_in_a = 16'h0100; d_in_b = 16'h0011; d_in_sub = 1'b0; d_in_cin = 1'b0;
    d_out_ready = 1'b1;
    @(posedge clk); #1;
    d_out_ready = 1'b0;
    check("bp_release", 64'({d_out_valid, d_in_ready}), 64'b01);
    run_op(16'h0100, 16'h0011, 1'b0, 1'b0, 16'h0111, 1'b0, 1'b0, "bp_next");

    // Reset in the middle of RUN, after two nibbles.
    issue(16'h0FFF, 16'h0001, 1'b0, 1'b0, "rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid_flags", 64'({d_out_valid, d_in_ready, d_busy}), 64'b010);
    check("rst_mid_sum", 64'(d_out_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst");

    // Randomized phase on all widths.
    rand_go = 1'b1;
    for (int t = 0; t < 45000; t++) begin
      if (g_rand[0].fin && g_rand[1].fin && g_rand[2].fin) break;
      @(posedge clk);
    end
    check("rand_finished", 64'({g_rand[0].fin, g_rand[1].fin, g_rand[2].fin}), 64'b111);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_cla_serial_add_ctrl
